// File: rtl/min_reduce_pkg.sv
// min_reduce_pkg: shared state encoding and default widths for the min reduction stage
package min_reduce_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam int DEF_WIDTH   = 64;
    localparam int DEF_COUNT_W = 32;
endpackage

// File: rtl/min_int64.sv
// min_int64: combinational signed minimum of two operands, keeping a on a tie
module min_int64 #(
    parameter int WIDTH     = 64,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic a_gt_b;
    if (IMPL_TYPE == 1) begin : g_sub
        logic [WIDTH:0] diff;
        // b - a on sign-extended operands cannot overflow, so its sign bit is a > b
        always_comb begin
            diff   = {b[WIDTH-1], b} - {a[WIDTH-1], a};
            a_gt_b = diff[WIDTH];
        end
    end else begin : g_cmp
        // direct signed magnitude comparison
        always_comb a_gt_b = $signed(a) > $signed(b);
    end
    // b only wins when strictly smaller
    always_comb y = a_gt_b ? b : a;
endmodule

// File: rtl/min_reduce_int64.sv
// min_reduce_int64: streaming signed min reduction emitting one {min, count} beat per packet
module min_reduce_int64
    import min_reduce_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int IMPL_TYPE = 0,
    parameter int COUNT_W   = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] out_count
);
    state_t state, nxt;
    logic [WIDTH-1:0] acc, min_y;
    logic [COUNT_W-1:0] count;
    logic take, give;
    min_int64 #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_min (
        .a(acc),
        .b(in_data),
        .y(min_y)
    );
    // handshakes, result gating and next state; outputs depend only on registered state
    always_comb begin
        in_ready  = !rst && state != DONE;
        out_valid = state == DONE;
        out_data  = out_valid ? acc : '0;
        out_count = out_valid ? count : '0;
        take      = in_valid && in_ready;
        give      = out_valid && out_ready;
        nxt       = state;
        if (state == DONE) nxt = give ? IDLE : DONE;
        else if (take) nxt = in_last ? DONE : ACCUM;
    end
    // state, running minimum and saturating element counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
        end else begin
            state <= nxt;
            if (take) begin
                acc   <= state == IDLE ? in_data : min_y;
                count <= state == IDLE ? COUNT_W'(1) : (&count ? count : count + COUNT_W'(1));
            end else if (give) begin
                count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_min_reduce_int64.sv
// tb_min_reduce_int64: table, directed and random checks of the min reduction stage against a queue model
module tb_min_reduce_int64;
    localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
    logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
    logic [63:0] in_data = '0;
    logic in_ready, out_valid, in_ready2, out_valid2;
    logic [63:0] out_data, out_data2;
    logic [31:0] out_count;
    logic [1:0] out_count2;
    int n_cmp = 0, n_err = 0;
    logic [63:0] cur[$];
    logic [95:0] exp_q[$];

    min_reduce_int64 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count)
    );
    min_reduce_int64 #(.WIDTH(64), .IMPL_TYPE(1), .COUNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_count(out_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: collect each accepted packet, reduce it with plain signed arithmetic on completion
    always @(negedge clk) begin
        if (rst) begin
            cur.delete();
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_result", 64'd1, 64'd0);
                else begin
                    logic [95:0] e;
                    e = exp_q.pop_front();
                    chk("sb_data", out_data, e[95:32]);
                    chk("sb_count", 64'(out_count), 64'(e[31:0]));
                    chk("sb_valid2", 64'(out_valid2), 64'd1);
                    chk("sb_data2", out_data2, e[95:32]);
                    chk("sb_count_sat", 64'(out_count2), e[31:0] > 3 ? 64'd3 : 64'(e[31:0]));
                end
            end
            if (in_valid && in_ready) begin
                cur.push_back(in_data);
                if (in_last) begin
                    logic signed [63:0] m;
                    m = cur[0];
                    foreach (cur[i]) if ($signed(cur[i]) < m) m = cur[i];
                    exp_q.push_back({m, 32'(cur.size())});
                    cur.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        int t = 0;
        in_valid = 1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 50) begin
            if (t >= 2) out_ready = 1;
            step();
            t++;
        end
        if (!in_ready) chk("send_timeout", 64'd1, 64'd0);
        step();
        in_valid = 0;
        in_last  = 0;
    endtask

    typedef struct {
        int len;
        logic [63:0] e [4];
        int gap;
        logic [63:0] md;
        logic [31:0] mc;
    } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{len: 4, e: '{64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD},
                   gap: 0, md: 64'hFFFF_FFFF_FFFF_FFFD, mc: 4};
        tbl[1] = '{len: 1, e: '{SMAX, 64'd0, 64'd0, 64'd0}, gap: 0, md: SMAX, mc: 1};
        tbl[2] = '{len: 4, e: '{64'd0, SMAX, SMIN, 64'd1}, gap: 2, md: SMIN, mc: 4};
        tbl[3] = '{len: 2, e: '{64'd5, 64'd5, 64'd0, 64'd0}, gap: 1, md: 64'd5, mc: 2};
        tbl[4] = '{len: 3, e: '{SMIN, SMAX, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0}, gap: 0, md: SMIN, mc: 3};
        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        step();
        rst = 0;
        step();
        chk("idle_ready", 64'(in_ready), 64'd1);

        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].len; i++) begin
                send(tbl[k].e[i], i == tbl[k].len - 1);
                if (i != tbl[k].len - 1) repeat (tbl[k].gap) step();
            end
            chk($sformatf("tbl%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("tbl%0d_data", k), out_data, tbl[k].md);
            chk($sformatf("tbl%0d_count", k), 64'(out_count), 64'(tbl[k].mc));
            chk($sformatf("tbl%0d_busy", k), 64'(in_ready), 64'd0);
            step();
            chk($sformatf("tbl%0d_drop", k), 64'(out_valid), 64'd0);
            chk($sformatf("tbl%0d_zero", k), out_data, 64'd0);
            chk($sformatf("tbl%0d_ready", k), 64'(in_ready), 64'd1);
        end

        out_ready = 0;
        send(64'd1, 0);
        send(64'd2, 1);
        in_valid = 1;
        in_data  = 64'd99;
        in_last  = 1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", out_data, 64'd1);
            chk("bp_count", 64'(out_count), 64'd2);
            chk("bp_ready", 64'(in_ready), 64'd0);
            step();
        end
        in_valid = 0;
        in_last  = 0;
        out_ready = 1;
        step();
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);

        send(64'hFFFF_FFFF_FFFF_FFF7, 0);
        send(64'd4, 0);
        #2 rst = 1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", out_data, 64'd0);
        chk("arst_count", 64'(out_count), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd0);
        step();
        rst = 0;
        step();
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        send(64'd6, 1);
        chk("post_rst_data", out_data, 64'd6);
        chk("post_rst_count", 64'(out_count), 64'd1);
        step();

        send(64'd3, 0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1);
        chk("b2b0_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("b2b0_count", 64'(out_count), 64'd2);
        send(64'hFFFF_FFFF_FFFF_FFF8, 1);
        chk("b2b1_data", out_data, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("b2b1_count", 64'(out_count), 64'd1);
        step();

        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                logic [63:0] d;
                int s;
                s = int'($urandom_range(0, 10)) - 5;
                case ($urandom_range(0, 5))
                    0: d = SMIN;
                    1: d = SMAX;
                    2: d = 64'(s);
                    default: d = {$urandom, $urandom};
                endcase
                out_ready = 1'($urandom_range(0, 1));
                send(d, i == len - 1);
                repeat ($urandom_range(0, 2)) step();
            end
        end
        out_ready = 1;
        repeat (5) step();
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
